// File: rtl/debounced_event_counter.sv
// debounced_event_counter: per-channel synchroniser, stable-time debounce,
// edge-qualified event counters and a registered channel readout.
module debounced_event_counter #(
  parameter int CHANNELS        = 4,
  parameter int COUNT_WIDTH     = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SATURATE        = 0,
  parameter int SEL_WIDTH       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    sw,
  input  logic                   edge_mode,
  input  logic                   count_clear,
  input  logic [SEL_WIDTH-1:0]   sel,
  output logic [CHANNELS-1:0]    debounced,
  output logic [CHANNELS-1:0]    event_pulse,
  output logic [CHANNELS-1:0]    overflow,
  output logic [COUNT_WIDTH-1:0] count_out
);

  localparam int DBW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  logic [CHANNELS-1:0]    r_s1;
  logic [CHANNELS-1:0]    r_s2;
  logic [COUNT_WIDTH-1:0] w_count [CHANNELS];
  logic [COUNT_WIDTH-1:0] w_sel_count;
  logic [COUNT_WIDTH-1:0] r_count_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DBW-1:0]         r_dbcnt;
    logic                   r_deb;
    logic                   r_pulse;
    logic                   r_ovf;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_mism;
    logic                   w_flip;
    logic                   w_qual;

    assign w_mism = r_s2[g] ^ r_deb;
    assign w_flip = w_mism && (r_dbcnt == DB_LAST);
    // Falling edges only count in edge_mode; never strobe twice in a row.
    assign w_qual = w_flip && (r_s2[g] || edge_mode) && !r_pulse;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_dbcnt <= '0;
        r_deb   <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_qual;
        if (!w_mism || w_flip) begin
          r_dbcnt <= '0;
        end else begin
          r_dbcnt <= r_dbcnt + DBW'(1);
        end
        if (w_flip) begin
          r_deb <= r_s2[g];
        end
      end
    end

    // Clear beats a coincident increment; that event is dropped.
    always_ff @(posedge clock) begin
      if (reset || count_clear) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (r_pulse) begin
        if (r_count == CMAX) begin
          r_ovf   <= 1'b1;
          r_count <= (SATURATE != 0) ? CMAX : '0;
        end else begin
          r_count <= r_count + COUNT_WIDTH'(1);
        end
      end
    end

    assign debounced[g]   = r_deb;
    assign event_pulse[g] = r_pulse;
    assign overflow[g]    = r_ovf;
    assign w_count[g]     = r_count;
  end

  always_comb begin
    w_sel_count = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        w_sel_count = w_count[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count_out <= '0;
    end else begin
      r_count_out <= w_sel_count;
    end
  end

  assign count_out = r_count_out;

endmodule

// File: tb/tb_debounced_event_counter.sv
// Bench for debounced_event_counter: directed sequences, a vector table
// and randomized stimulus against a cycle-count reference model.
module tb_debounced_event_counter;

  localparam int CH   = 4;
  localparam int CW   = 4;
  localparam int DB   = 4;
  localparam int MAXC = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] sw;
  logic          edge_mode;
  logic          count_clear;
  logic [1:0]    sel;

  logic [CH-1:0] deb0, pul0, ovf0;
  logic [CH-1:0] deb1, pul1, ovf1;
  logic [CW-1:0] cout0, cout1;

  debounced_event_counter #(
    .CHANNELS(CH), .COUNT_WIDTH(CW), .DEBOUNCE_CYCLES(DB),
    .SATURATE(0), .SEL_WIDTH(2)
  ) u_wrap (
    .clock(clock), .reset(reset), .sw(sw),
    .edge_mode(edge_mode), .count_clear(count_clear), .sel(sel),
    .debounced(deb0), .event_pulse(pul0),
    .overflow(ovf0), .count_out(cout0)
  );

  debounced_event_counter #(
    .CHANNELS(CH), .COUNT_WIDTH(CW), .DEBOUNCE_CYCLES(DB),
    .SATURATE(1), .SEL_WIDTH(2)
  ) u_sat (
    .clock(clock), .reset(reset), .sw(sw),
    .edge_mode(edge_mode), .count_clear(count_clear), .sel(sel),
    .debounced(deb1), .event_pulse(pul1),
    .overflow(ovf1), .count_out(cout1)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;
  int pulses0 = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc_w(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with it for DB consecutive edges since it last agreed.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_pul = '0;
  int            m_agree [CH] = '{default: 0};
  int            m_cnt [2][CH] = '{default: 0};
  logic [CH-1:0] m_ovf [2] = '{default: '0};
  int            m_cout [2] = '{default: 0};
  int            cyc = 0;

  always @(posedge clock) begin : p_model
    logic [CH-1:0] nxt_pul;
    int nxt;
    cyc++;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pul = '0;
      for (int k = 0; k < 2; k++) begin
        m_ovf[k] = '0;
        m_cout[k] = 0;
        for (int i = 0; i < CH; i++) m_cnt[k][i] = 0;
      end
      for (int i = 0; i < CH; i++) m_agree[i] = cyc;
    end else begin
      for (int k = 0; k < 2; k++) m_cout[k] = m_cnt[k][sel];
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < CH; i++) begin
          if (count_clear) begin
            m_cnt[k][i] = 0;
            m_ovf[k][i] = 1'b0;
          end else if (m_pul[i]) begin
            nxt = m_cnt[k][i] + 1;
            if (nxt > MAXC) m_ovf[k][i] = 1'b1;
            if (k == 0) m_cnt[k][i] = nxt % (MAXC + 1);
            else m_cnt[k][i] = (nxt > MAXC) ? MAXC : nxt;
          end
        end
      end
      nxt_pul = '0;
      for (int i = 0; i < CH; i++) begin
        if (m_s2[i] == m_deb[i]) begin
          m_agree[i] = cyc;
        end else if (cyc - m_agree[i] >= DB) begin
          m_deb[i] = m_s2[i];
          m_agree[i] = cyc;
          nxt_pul[i] = (m_deb[i] | edge_mode) & ~m_pul[i];
        end
      end
      m_pul = nxt_pul;
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_deb_wrap", deb0, m_deb);
      chk("model_pulse_wrap", pul0, m_pul);
      chk("model_ovf_wrap", ovf0, m_ovf[0]);
      chk("model_cout_wrap", cout0, m_cout[0]);
      chk("model_deb_sat", deb1, m_deb);
      chk("model_pulse_sat", pul1, m_pul);
      chk("model_ovf_sat", ovf1, m_ovf[1]);
      chk("model_cout_sat", cout1, m_cout[1]);
      if (pul0[0]) pulses0++;
    end
  end

  typedef struct {
    logic [CH-1:0] sw;
    logic [1:0]    sel;
    int            waitc;
    logic [CW-1:0] cout;
    logic [CH-1:0] deb;
  } vec_t;

  vec_t tv [9];

  initial begin
    tv[0] = '{4'b0110, 2'd0, 10, 4'd0, 4'b0110};
    tv[1] = '{4'b0110, 2'd1, 1, 4'd1, 4'b0110};
    tv[2] = '{4'b0110, 2'd2, 1, 4'd1, 4'b0110};
    tv[3] = '{4'b0110, 2'd3, 1, 4'd0, 4'b0110};
    tv[4] = '{4'b0000, 2'd1, 10, 4'd1, 4'b0000};
    tv[5] = '{4'b1111, 2'd3, 10, 4'd1, 4'b1111};
    tv[6] = '{4'b1111, 2'd1, 1, 4'd2, 4'b1111};
    tv[7] = '{4'b1111, 2'd0, 1, 4'd1, 4'b1111};
    tv[8] = '{4'b0000, 2'd2, 10, 4'd2, 4'b0000};

    reset = 1'b1; sw = '0; edge_mode = 1'b0;
    count_clear = 1'b0; sel = '0;
    cyc_w(2);
    chk_en = 1'b1;
    chk("reset_cout", cout0, 0);
    chk("reset_deb", deb0, 0);
    chk("reset_ovf", ovf0, 0);
    chk("reset_pulse", pul0, 0);
    reset = 1'b0;
    cyc_w(2);

    // Clean press
    sw[0] = 1'b1;
    cyc_w(5);
    chk("press_deb_e5", deb0[0], 0);
    cyc_w(1);
    chk("press_deb_e6", deb0[0], 1);
    chk("press_pulse_e6", pul0[0], 1);
    cyc_w(1);
    chk("press_pulse_e7", pul0[0], 0);
    chk("press_cout_e7", cout0, 0);
    cyc_w(1);
    chk("press_cout_e8", cout0, 1);
    cyc_w(6);
    sw[0] = 1'b0;
    cyc_w(10);
    chk("release_cout", cout0, 1);
    chk("release_deb", deb0[0], 0);

    // Bounce, then a short glitch
    count_clear = 1'b1; cyc_w(1); count_clear = 1'b0;
    cyc_w(1);
    chk("clear_cout", cout0, 0);
    pulses0 = 0;
    for (int k = 0; k < 12; k++) begin
      sw[0] = ((k / 2) % 2 == 0);
      cyc_w(1);
    end
    sw[0] = 1'b1;
    cyc_w(12);
    chk("bounce_pulses", pulses0, 1);
    chk("bounce_cout", cout0, 1);
    sw[0] = 1'b0;
    cyc_w(10);
    pulses0 = 0;
    sw[0] = 1'b1; cyc_w(3); sw[0] = 1'b0;
    cyc_w(10);
    chk("glitch_pulses", pulses0, 0);
    chk("glitch_deb", deb0[0], 0);
    chk("glitch_cout", cout0, 1);

    // Wrap versus saturate
    count_clear = 1'b1; cyc_w(1); count_clear = 1'b0;
    for (int p = 1; p <= 17; p++) begin
      sw[0] = 1'b1; cyc_w(6);
      sw[0] = 1'b0; cyc_w(8);
      if (p == 15) begin
        chk("p15_cout_wrap", cout0, 15);
        chk("p15_ovf_wrap", ovf0[0], 0);
        chk("p15_cout_sat", cout1, 15);
        chk("p15_ovf_sat", ovf1[0], 0);
      end
      if (p == 16) begin
        chk("p16_cout_wrap", cout0, 0);
        chk("p16_ovf_wrap", ovf0[0], 1);
        chk("p16_cout_sat", cout1, 15);
        chk("p16_ovf_sat", ovf1[0], 1);
      end
    end
    chk("p17_cout_wrap", cout0, 1);
    chk("p17_ovf_wrap", ovf0[0], 1);
    chk("p17_cout_sat", cout1, 15);
    chk("p17_ovf_sat", ovf1[0], 1);

    // Both edges
    count_clear = 1'b1; cyc_w(1); count_clear = 1'b0;
    cyc_w(1);
    chk("clear_ovf_wrap", ovf0[0], 0);
    chk("clear_ovf_sat", ovf1[0], 0);
    edge_mode = 1'b1;
    repeat (3) begin
      sw[0] = 1'b1; cyc_w(8);
      sw[0] = 1'b0; cyc_w(8);
    end
    chk("both_edges_cout", cout0, 6);
    edge_mode = 1'b0;

    // Clear on the same edge as an increment
    sw[0] = 1'b1;
    cyc_w(6);
    chk("collide_pulse", pul0[0], 1);
    count_clear = 1'b1; cyc_w(1); count_clear = 1'b0;
    cyc_w(4);
    chk("collide_cout", cout0, 0);
    chk("collide_ovf", ovf0[0], 0);
    sw[0] = 1'b0;
    cyc_w(10);

    // Reset mid-debounce with input held
    sw[0] = 1'b1;
    cyc_w(4);
    reset = 1'b1; cyc_w(1); reset = 1'b0;
    chk("rst_mid_deb", deb0[0], 0);
    cyc_w(5);
    chk("rst_requal_e10", deb0[0], 0);
    cyc_w(1);
    chk("rst_requal_e11", deb0[0], 1);
    sw[0] = 1'b0;
    cyc_w(10);
    count_clear = 1'b1; cyc_w(1); count_clear = 1'b0;
    cyc_w(2);

    // Channel independence table
    for (int k = 0; k < 9; k++) begin
      sw  = tv[k].sw;
      sel = tv[k].sel;
      cyc_w(tv[k].waitc);
      chk($sformatf("vec%0d_cout_wrap", k), cout0, tv[k].cout);
      chk($sformatf("vec%0d_cout_sat", k), cout1, tv[k].cout);
      chk($sformatf("vec%0d_deb", k), deb0, tv[k].deb);
    end

    // Random traffic with clears and resets
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) sw[i] = ~sw[i];
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) edge_mode = ~edge_mode;
      count_clear = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 299) == 0);
      cyc_w(1);
    end
    count_clear = 1'b0;
    reset = 1'b0;

    // Long run without clears to reach overflow
    edge_mode = 1'b1;
    for (int t = 0; t < 1200; t++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 6) == 0) sw[i] = ~sw[i];
      sel = 2'($urandom_range(0, 3));
      cyc_w(1);
    end

    cyc_w(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/debounced_event_counter.md
# debounced_event_counter

Parametrised, multi-channel successor to the single-switch debounced counter. Each of `CHANNELS` raw switch/button inputs is synchronised, debounced by a stable-time filter and edge-detected, and every qualified edge increments that channel's counter; counters wrap or saturate and raise a sticky overflow flag. One channel's count is selected onto a registered output that feeds the seven-segment display FSM.

## Interface
- `CHANNELS`, 4: number of independent input channels (1..16).
- `COUNT_WIDTH`, 8: width of each event counter.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a level change (≥1; 10 ms at 100 MHz).
- `SATURATE`, 0: 0 = counters wrap at max; 1 = counters hold at max.
- `SEL_WIDTH`, 2: width of `sel`; must satisfy 2^`SEL_WIDTH` ≥ `CHANNELS`.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  `CHANNELS`  raw asynchronous switch/button levels.
- `edge_mode`  in  1  0 = count rising edges only; 1 = count rising and falling edges.
- `count_clear`  in  1  synchronous clear of all counters and overflow flags.
- `sel`  in  `SEL_WIDTH`  channel whose count drives `count_out`.
- `debounced`  out  `CHANNELS`  filtered level per channel.
- `event_pulse`  out  `CHANNELS`  one-cycle strobe per accepted qualifying edge.
- `overflow`  out  `CHANNELS`  sticky flag, set when an increment hits a counter already at max.
- `count_out`  out  `COUNT_WIDTH`  registered count of channel `sel`.

## Operation
- Per channel: 2-flop synchroniser (`s1`, `s2`) → debounce counter (width clog2(`DEBOUNCE_CYCLES`), min 1) → `debounced` register → edge detect → event counter.
- Debounce: on each edge where `s2` ≠ `debounced`, the counter increments; on any edge where `s2` = `debounced`, it is cleared to 0. When `s2` ≠ `debounced` and the counter = `DEBOUNCE_CYCLES`-1, `debounced` ← `s2`, counter ← 0. A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `debounced`.
- `event_pulse[i]` is registered on the same edge `debounced[i]` flips: high for 1 cycle if the flip is 0→1, or if the flip is 1→0 and `edge_mode`=1. It is never high for 2 consecutive cycles.
- Counter: on the edge after `event_pulse[i]`=1, count ← count+1. At max (2^`COUNT_WIDTH`-1): `SATURATE`=0 → wraps to 0; `SATURATE`=1 → holds at max. In both cases `overflow[i]` ← 1 and stays set until clear/reset.
- `count_clear`=1: all counts and `overflow` ← 0 on that edge; clear wins over a simultaneous increment (that event is lost). Synchroniser, debounce and `debounced` state are unaffected.
- `count_out` ← count[`sel`] each edge; `sel` ≥ `CHANNELS` → `count_out` ← 0.
- Channels are fully independent; simultaneous events on several channels are all counted.

## Timing
- Reset (synchronous): `s1`, `s2`, debounce counters, `debounced`, `event_pulse`, counts, `overflow`, `count_out` all ← 0. A reset mid-debounce discards the partial count, and a press held through reset is re-qualified from scratch.
- A `sw[i]` level change set up before edge E1 appears in `s2` after E2; `debounced[i]` and `event_pulse[i]` change at edge E(2+`DEBOUNCE_CYCLES`); the count updates at E(3+D); `count_out` shows it at E(4+D).
- `sel` change → `count_out` updates 1 edge later.
- `count_clear` at edge E → `count_out`=0 from edge E+1 (the count is 0 after E).

## Test plan
Use `CHANNELS`=4, `COUNT_WIDTH`=4, `DEBOUNCE_CYCLES`=4, `sel`=0 unless stated.
- Clean press: `sw[0]` 0→1 before E1, held for 10 cycles, then released → `debounced[0]`=1 after E6, `event_pulse[0]` high for exactly 1 cycle, `count_out`=1 after E8; release with `edge_mode`=0 → count stays 1.
- Bounce: `sw[0]` toggles every 2 cycles for 12 cycles, then holds 1 → exactly one `event_pulse[0]`, `count_out`=1; a 3-cycle glitch alone → no event.
- Wrap/saturate: 17 presses with `SATURATE`=0 → `count_out`=1, `overflow[0]`=1 from the 16th press on; same stimulus with `SATURATE`=1 → `count_out`=15, `overflow[0]`=1.
- Both edges: `edge_mode`=1, 3 full press/release cycles → `count_out`=6.
- Clear/reset collisions: `count_clear` on the same edge as an increment → count 0, `overflow` 0. `reset` after 2 mismatch cycles → `debounced`=0, and a held input needs 4 more stable cycles after `s2` recovers.
- Independence: `sw[1]` and `sw[2]` pressed on the same cycle → `sel`=1 and `sel`=2 each read 1; `sel`=3 reads 0; `sel`=0 reads 0.
